// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU and its two-port arbiter/sequencer.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
// Contents: ALUControl op codes, flag bit positions, FSM state enum, op_legal().
package alu_ctrl_pkg;

   localparam int N_PORTS = 2;
   localparam int DATA_W  = 32;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Bit positions inside the 4-bit {N, Z, C, V} flag vector.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   function automatic logic op_legal(input logic [2:0] op);
      logic legal;
      case (op)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: add, sub, and, or, set-less-than; flags {N, Z, C, V}.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b (operands), alu_control (op code), result, alu_flags {N, Z, C, V}.
module alu
   import alu_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        alu_control,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        alu_flags
);

   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum;
   logic              overflow;

   // One shared adder: alu_control[0] selects subtract (invert b, carry in 1).
   assign b_eff = alu_control[0] ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, alu_control[0]};

   // Signed overflow only exists for the adder ops; logic ops force it low.
   assign overflow = ~alu_control[1]
                   & ~(alu_control[0] ^ a[DATA_W-1] ^ b[DATA_W-1])
                   & (sum[DATA_W-1] ^ a[DATA_W-1]);

   always_comb begin
      result = 32'hDEADBEEF;
      case (alu_control)
         ALU_ADD, ALU_SUB: result = sum[DATA_W-1:0];
         ALU_AND:          result = a & b;
         ALU_OR:           result = a | b;
         ALU_SLT:          result = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ overflow};
         default:          result = 32'hDEADBEEF;
      endcase
   end

   always_comb begin
      alu_flags         = '0;
      alu_flags[FLAG_N] = result[DATA_W-1];
      // Zero is only meaningful for the compare-style ops (sub, slt).
      alu_flags[FLAG_Z] = (alu_control[1:0] == 2'b01) && (result == '0);
      alu_flags[FLAG_C] = ~alu_control[1] & sum[DATA_W];
      alu_flags[FLAG_V] = overflow;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Latency: accept in cycle T, response valid from T+2; min 3 cycles between accepts.
// Backpressure: req_ready low while an op is in flight; response held until owner's rsp_ready.
// Ports: clk, reset (sync, active-high); req_valid/req_ready[1:0] with per-port
//        req_op*/req_a*/req_b*; rsp_valid (one-hot owner)/rsp_ready[1:0] with
//        rsp_result, rsp_flags {N,Z,C,V}, rsp_err (illegal op); busy (not IDLE).
module alu_arbiter
   import alu_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_PORTS-1:0]   req_valid,
   output logic [N_PORTS-1:0]   req_ready,
   input  logic [2:0]           req_op0,
   input  logic [2:0]           req_op1,
   input  logic [DATA_W-1:0]    req_a0,
   input  logic [DATA_W-1:0]    req_a1,
   input  logic [DATA_W-1:0]    req_b0,
   input  logic [DATA_W-1:0]    req_b1,
   output logic [N_PORTS-1:0]   rsp_valid,
   input  logic [N_PORTS-1:0]   rsp_ready,
   output logic [DATA_W-1:0]    rsp_result,
   output logic [3:0]           rsp_flags,
   output logic                 rsp_err,
   output logic                 busy
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              prio;       // port that wins when both request
   logic              gnt_id;     // owner of the in-flight operation
   logic              arb_gnt;    // port picked this cycle in IDLE
   logic              any_req;
   logic              accept;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_flags;

   assign any_req = |req_valid;
   assign arb_gnt = (req_valid == 2'b11) ? prio : req_valid[1];
   // In IDLE the granted port always has valid high, so any request transfers.
   assign accept  = (state == ST_IDLE) && any_req;

   alu u_alu (
      .a           (a_q),
      .b           (b_q),
      .alu_control (op_q),
      .result      (alu_result),
      .alu_flags   (alu_flags)
   );

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         ST_IDLE: begin
            if (any_req && !reset) begin
               req_ready[arb_gnt] = 1'b1;
               state_nxt          = ST_EXEC;
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: begin
            // Only the owner's rsp_ready can retire the response.
            if (rsp_ready[gnt_id]) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign rsp_valid = (state == ST_RESP) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         prio       <= 1'b0;
         gnt_id     <= 1'b0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            gnt_id <= arb_gnt;
            prio   <= ~arb_gnt;
            op_q   <= arb_gnt ? req_op1 : req_op0;
            a_q    <= arb_gnt ? req_a1  : req_a0;
            b_q    <= arb_gnt ? req_b1  : req_b0;
         end
         // Response registers load once per op, so they stay stable through RESP.
         if (state == ST_EXEC) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= ~op_legal(op_q);
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [2:0]  req_op0, req_op1;
   logic [31:0] req_a0, req_a1, req_b0, req_b1;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        rsp_err;
   logic        busy;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flags;   // {N, Z, C, V}
      logic        err;
   } vec_t;

   vec_t        vecs [12];
   int          grants[$];
   int          acc_cyc[$];
   int          cnt [2];
   logic [1:0]  fire;
   logic [1:0]  exp_rr;
   int          m_active, m_owner, m_start, m_prio, g;
   logic [36:0] m_exp;
   logic [2:0]  op_list [7];

   alu_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op0    (req_op0),
      .req_op1    (req_op1),
      .req_a0     (req_a0),
      .req_a1     (req_a1),
      .req_b0     (req_b0),
      .req_b1     (req_b1),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] oh(input int p);
      return (p == 0) ? 2'b01 : 2'b10;
   endfunction

   // Reference: {err, N, Z, C, V, result} from plain arithmetic on the op meaning.
   function automatic logic [36:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v, z, e;
      c = 1'b0; v = 1'b0; e = 1'b0; r = 32'hDEADBEEF;
      case (op)
         3'b000: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'b001, 3'b101: begin
            r = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
            if (op == 3'b101) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         end
         3'b010: r = a & b;
         3'b011: r = a | b;
         default: e = 1'b1;
      endcase
      z = ((op == 3'b001) || (op == 3'b101)) && (r == 32'd0);
      return {e, r[31], z, c, v, r};
   endfunction

   task automatic set_req(input int p, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      if (p == 0) begin
         req_op0 = op; req_a0 = a; req_b0 = b;
      end else begin
         req_op1 = op; req_a1 = a; req_b1 = b;
      end
      req_valid[p] = 1'b1;
   endtask

   function automatic logic [31:0] rnd_opnd();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'h0;
         1: v = 32'h1;
         2: v = 32'h7FFFFFFF;
         3: v = 32'h80000000;
         4: v = 32'hFFFFFFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic drain(input string name);
      int n;
      n = 0;
      smp();
      while (busy && n < 12) begin
         step();
         smp();
         n++;
      end
      chk(name, {63'd0, busy}, 64'd0);
      step();
   endtask

   initial begin
      vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1'b0};
      vecs[1]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 1'b0};
      vecs[2]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1'b0};
      vecs[3]  = '{3'b011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1'b0};
      vecs[4]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0010, 1'b0};
      vecs[5]  = '{3'b101, 32'h00000002, 32'h00000002, 32'h00000000, 4'b0110, 1'b0};
      vecs[6]  = '{3'b111, 32'h00000001, 32'h00000002, 32'hDEADBEEF, 4'b1000, 1'b1};
      vecs[7]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0010, 1'b0};
      vecs[8]  = '{3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, 1'b0};
      vecs[9]  = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1'b0};
      vecs[10] = '{3'b110, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 4'b1000, 1'b1};
      vecs[11] = '{3'b010, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 1'b0};
      op_list = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

      reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
      step(); step();
      reset = 1'b0;
      smp();
      chk("reset_busy",      {63'd0, busy}, 64'd0);
      chk("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      chk("reset_req_ready", {62'd0, req_ready}, 64'd0);
      chk("reset_result",    {32'd0, rsp_result}, 64'd0);
      chk("reset_flags_err", {59'd0, rsp_flags, rsp_err}, 64'd0);
      step();

      // Table vectors, alternating ports, rsp_ready held high.
      for (int i = 0; i < 12; i++) begin
         int p;
         p = i % 2;
         rsp_ready = 2'b11;
         set_req(p, vecs[i].op, vecs[i].a, vecs[i].b);
         smp();
         chk($sformatf("tbl%0d_accept", i), {62'd0, req_ready}, {62'd0, oh(p)});
         step();
         req_valid = 2'b00;
         smp();
         chk($sformatf("tbl%0d_exec_valid", i), {62'd0, rsp_valid}, 64'd0);
         chk($sformatf("tbl%0d_exec_busy", i), {63'd0, busy}, 64'd1);
         step();
         smp();
         chk($sformatf("tbl%0d_rsp_valid", i), {62'd0, rsp_valid}, {62'd0, oh(p)});
         chk($sformatf("tbl%0d_result", i), {32'd0, rsp_result}, {32'd0, vecs[i].res});
         chk($sformatf("tbl%0d_flags", i), {60'd0, rsp_flags}, {60'd0, vecs[i].flags});
         chk($sformatf("tbl%0d_err", i), {63'd0, rsp_err}, {63'd0, vecs[i].err});
         step();
      end

      // Contention: last grant went to port 1, so port 0 leads.
      rsp_ready = 2'b11;
      cnt[0] = 0; cnt[1] = 0;
      set_req(0, 3'b000, 32'd10, 32'd1);
      set_req(1, 3'b000, 32'd20, 32'd2);
      for (int c = 0; c < 60 && (cnt[0] < 4 || cnt[1] < 4); c++) begin
         int p;
         smp();
         fire = req_valid & req_ready;
         step();
         if (fire != 2'b00) begin
            p = fire[1] ? 1 : 0;
            grants.push_back(p);
            acc_cyc.push_back(c);
            cnt[p]++;
            if (cnt[p] == 4) req_valid[p] = 1'b0;
            else set_req(p, 3'b000, $urandom, $urandom);
         end
      end
      req_valid = 2'b00;
      chk("cont_count", 64'(grants.size()), 64'd8);
      for (int k = 0; k < grants.size(); k++)
         chk($sformatf("cont_order%0d", k), 64'(grants[k]), 64'(k % 2));
      for (int k = 1; k < acc_cyc.size(); k++)
         chk($sformatf("cont_gap%0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd3);
      drain("cont_drain");

      // Backpressure on port 0 with port 1 waiting.
      rsp_ready = 2'b00;
      set_req(0, 3'b010, 32'hF0F0F0F0, 32'hFF00FF00);
      smp();
      chk("bp_accept", {62'd0, req_ready}, 64'd1);
      step();
      req_valid[0] = 1'b0;
      set_req(1, 3'b000, 32'd3, 32'd4);
      smp();
      chk("bp_exec_ready", {62'd0, req_ready}, 64'd0);
      step();
      for (int k = 0; k < 5; k++) begin
         rsp_ready = (k % 2 == 1) ? 2'b10 : 2'b00;
         smp();
         chk($sformatf("bp_hold_valid%0d", k), {62'd0, rsp_valid}, 64'd1);
         chk($sformatf("bp_hold_result%0d", k), {32'd0, rsp_result}, 64'hF000F000);
         chk($sformatf("bp_hold_ready%0d", k), {62'd0, req_ready}, 64'd0);
         step();
      end
      rsp_ready = 2'b01;
      smp();
      chk("bp_handshake_valid", {62'd0, rsp_valid}, 64'd1);
      chk("bp_no_bypass", {62'd0, req_ready}, 64'd0);
      step();
      rsp_ready = 2'b11;
      smp();
      chk("bp_p1_accept", {62'd0, req_ready}, 64'd2);
      step();
      req_valid = 2'b00;
      smp();
      step();
      smp();
      chk("bp_p1_rsp_valid", {62'd0, rsp_valid}, 64'd2);
      chk("bp_p1_result", {32'd0, rsp_result}, 64'd7);
      step();

      // Reset while port 0's response is pending (prio points at 1 here).
      rsp_ready = 2'b00;
      set_req(0, 3'b000, 32'd1, 32'd1);
      smp();
      chk("rr_accept", {62'd0, req_ready}, 64'd1);
      step();
      req_valid = 2'b00;
      smp();
      step();
      smp();
      chk("rr_pre_valid", {62'd0, rsp_valid}, 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      smp();
      chk("rr_busy", {63'd0, busy}, 64'd0);
      chk("rr_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      chk("rr_req_ready", {62'd0, req_ready}, 64'd0);
      chk("rr_result", {32'd0, rsp_result}, 64'd0);
      chk("rr_flags_err", {59'd0, rsp_flags, rsp_err}, 64'd0);
      rsp_ready = 2'b11;
      step();
      set_req(0, 3'b000, 32'd2, 32'd2);
      set_req(1, 3'b001, 32'd9, 32'd4);
      smp();
      chk("rr_prio_reset", {62'd0, req_ready}, 64'd1);
      step();
      req_valid[0] = 1'b0;
      smp();
      step();
      smp();
      chk("rr_p0_result", {32'd0, rsp_result}, 64'd4);
      step();
      smp();
      chk("rr_p1_grant", {62'd0, req_ready}, 64'd2);
      step();
      req_valid = 2'b00;
      smp();
      step();
      smp();
      chk("rr_p1_rsp_valid", {62'd0, rsp_valid}, 64'd2);
      chk("rr_p1_result", {32'd0, rsp_result}, 64'd5);
      step();

      // Randomized traffic against a transaction-level scoreboard.
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_active = 0; m_owner = 0; m_start = 0; m_prio = 0; m_exp = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rsp_ready = 2'($urandom_range(0, 3));
         smp();
         if (m_active == 0) begin
            if (req_valid == 2'b11) g = m_prio;
            else g = req_valid[1] ? 1 : 0;
            exp_rr = (req_valid == 2'b00) ? 2'b00 : oh(g);
            chk("rnd_req_ready", {62'd0, req_ready}, {62'd0, exp_rr});
            chk("rnd_idle_valid", {62'd0, rsp_valid}, 64'd0);
            if (req_valid != 2'b00) begin
               m_active = 1;
               m_owner  = g;
               m_start  = cyc;
               m_prio   = 1 - g;
               m_exp    = (g == 0) ? ref_alu(req_op0, req_a0, req_b0)
                                   : ref_alu(req_op1, req_a1, req_b1);
            end
         end else begin
            chk("rnd_busy_ready", {62'd0, req_ready}, 64'd0);
            if (cyc == m_start + 1) begin
               chk("rnd_exec_valid", {62'd0, rsp_valid}, 64'd0);
            end else begin
               chk("rnd_rsp_valid", {62'd0, rsp_valid}, {62'd0, oh(m_owner)});
               chk("rnd_rsp_data", {27'd0, rsp_err, rsp_flags, rsp_result}, {27'd0, m_exp});
               if (rsp_ready[m_owner]) m_active = 0;
            end
         end
         fire = req_valid & req_ready;
         step();
         for (int p = 0; p < 2; p++) begin
            if (fire[p] || !req_valid[p]) begin
               if ($urandom_range(0, 2) != 0)
                  set_req(p, op_list[$urandom_range(0, 6)], rnd_opnd(), rnd_opnd());
               else
                  req_valid[p] = 1'b0;
            end
         end
      end
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      drain("rnd_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
